// File: rtl/runway_scheduler_if.sv
// Request/grant handshake bundle between the command decoder, the runway
// scheduler and the reply encoder.
//   req_valid/req_ready/req_id/req_emergency : request from the decoder
//   grant_valid/grant_ready/grant_id/grant_runway : grant to the encoder
// master : decoder/encoder side (drives requests, accepts grants)
// slave  : scheduler side (accepts requests, offers grants)
interface runway_scheduler_if #(
   parameter int ID_W = 4
);
   logic            req_valid;
   logic            req_ready;
   logic [ID_W-1:0] req_id;
   logic            req_emergency;
   logic            grant_valid;
   logic            grant_ready;
   logic [ID_W-1:0] grant_id;
   logic            grant_runway;

   modport master (
      output req_valid, req_id, req_emergency, grant_ready,
      input  req_ready, grant_valid, grant_id, grant_runway
   );

   modport slave (
      input  req_valid, req_id, req_emergency, grant_ready,
      output req_ready, grant_valid, grant_id, grant_runway
   );
endinterface

// File: rtl/runway_scheduler.sv
// Runway scheduler: allocates two runways among aircraft requests, queues
// normal requests in a FIFO, holds one emergency request in a dedicated slot,
// and offers one grant at a time to the reply encoder.
// Ports:
//   clock, reset (sync, active-low)
//   bus               : request/grant handshake (slave modport)
//   rel_valid/rel_runway/rel_id : runway release pulse
//   runway_override   : per-runway block of new normal grants
//   emergency_override: operator cancel of emergency mode
//   runway_active     : occupied bit per runway
//   emergency         : emergency mode flag
//   rel_error         : one-cycle pulse on an invalid release
//   queue_count       : number of queued normal requests
module runway_scheduler #(
   parameter int QUEUE_DEPTH = 4,
   parameter int ID_W        = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   runway_scheduler_if.slave            bus,
   input  logic                         rel_valid,
   input  logic                         rel_runway,
   input  logic [ID_W-1:0]              rel_id,
   input  logic [1:0]                   runway_override,
   input  logic                         emergency_override,
   output logic [1:0]                   runway_active,
   output logic                         emergency,
   output logic                         rel_error,
   output logic [$clog2(QUEUE_DEPTH):0] queue_count
);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

   typedef enum logic {IDLE, OFFER} state_t;
   typedef enum logic [1:0] {SRC_SLOT, SRC_FIFO, SRC_IN_EM, SRC_IN_NORM} src_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] fifo_q [QUEUE_DEPTH];
   logic [ID_W-1:0] fifo_d [QUEUE_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic            em_pending_q, em_pending_d;
   logic [ID_W-1:0] em_id_q, em_id_d;
   logic            emergency_q, emergency_d;
   logic [1:0]      occ_q, occ_d;
   logic [1:0]      own_em_q, own_em_d;
   logic [ID_W-1:0] owner_q [2];
   logic [ID_W-1:0] owner_d [2];
   logic [ID_W-1:0] grant_id_q, grant_id_d;
   logic            grant_runway_q, grant_runway_d;
   logic            rel_error_q, rel_error_d;

   logic            full;
   logic            accept;
   logic            acc_em;
   logic            acc_norm;
   logic            cand_valid;
   logic            cand_em;
   logic [ID_W-1:0] cand_id;
   src_t            cand_src;
   logic [1:0]      elig;
   logic            pick;
   logic            do_grant;
   logic            push;
   logic            pop;
   logic            rel_hit;

   // req_ready depends on registered state only, so the decoder never sees
   // a combinational path from its own request back to ready.
   assign full          = (count_q == FULL_CNT);
   assign bus.req_ready = !full && !em_pending_q;
   assign accept        = bus.req_valid && bus.req_ready;
   // An operator cancel in the same cycle discards an incoming emergency.
   assign acc_em        = accept && bus.req_emergency && !emergency_override;
   assign acc_norm      = accept && !bus.req_emergency;

   // Candidate selection: stored requests first (emergency slot, then FIFO
   // head while not in emergency mode); with nothing stored, the request
   // arriving this cycle may be granted directly for single-cycle latency.
   always_comb begin
      cand_valid = 1'b0;
      cand_em    = 1'b0;
      cand_id    = '0;
      cand_src   = SRC_SLOT;
      if (em_pending_q) begin
         if (!emergency_override) begin
            cand_valid = 1'b1;
            cand_em    = 1'b1;
            cand_id    = em_id_q;
            cand_src   = SRC_SLOT;
         end
      end else if (!emergency_q && (count_q != '0)) begin
         cand_valid = 1'b1;
         cand_id    = fifo_q[rd_ptr_q];
         cand_src   = SRC_FIFO;
      end else if (acc_em) begin
         cand_valid = 1'b1;
         cand_em    = 1'b1;
         cand_id    = bus.req_id;
         cand_src   = SRC_IN_EM;
      end else if (acc_norm && !emergency_q) begin
         cand_valid = 1'b1;
         cand_id    = bus.req_id;
         cand_src   = SRC_IN_NORM;
      end
      // Emergency grants ignore the override; occupancy is the registered
      // value, so a runway released this cycle is not yet eligible.
      elig     = cand_em ? ~occ_q : (~occ_q & ~runway_override);
      pick     = elig[0] ? 1'b0 : 1'b1;
      do_grant = (state_q == IDLE) && cand_valid && (elig != 2'b00);
   end

   always_comb begin
      state_d        = state_q;
      fifo_d         = fifo_q;
      rd_ptr_d       = rd_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      count_d        = count_q;
      em_pending_d   = em_pending_q;
      em_id_d        = em_id_q;
      emergency_d    = emergency_q;
      occ_d          = occ_q;
      own_em_d       = own_em_q;
      owner_d        = owner_q;
      grant_id_d     = grant_id_q;
      grant_runway_d = grant_runway_q;
      rel_error_d    = 1'b0;

      rel_hit = rel_valid && occ_q[rel_runway] && (owner_q[rel_runway] == rel_id);
      push    = acc_norm && !(do_grant && (cand_src == SRC_IN_NORM));
      pop     = do_grant && (cand_src == SRC_FIFO);

      if ((state_q == OFFER) && bus.grant_ready) begin
         state_d = IDLE;
      end

      if (do_grant) begin
         state_d         = OFFER;
         grant_id_d      = cand_id;
         grant_runway_d  = pick;
         occ_d[pick]     = 1'b1;
         own_em_d[pick]  = cand_em;
         owner_d[pick]   = cand_id;
         if (cand_src == SRC_SLOT) begin
            em_pending_d = 1'b0;
         end
      end

      // The released runway is occupied, so it never collides with the
      // runway picked for a same-cycle grant.
      if (rel_valid) begin
         if (rel_hit) begin
            occ_d[rel_runway]    = 1'b0;
            own_em_d[rel_runway] = 1'b0;
            // Keep emergency mode while a further emergency is still waiting.
            if (own_em_q[rel_runway] && !em_pending_q) begin
               emergency_d = 1'b0;
            end
         end else begin
            rel_error_d = 1'b1;
         end
      end

      if (acc_em) begin
         emergency_d = 1'b1;
         if (!(do_grant && (cand_src == SRC_IN_EM))) begin
            em_pending_d = 1'b1;
            em_id_d      = bus.req_id;
         end
      end

      if (push) begin
         fifo_d[wr_ptr_q] = bus.req_id;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Operator cancel wins over everything emergency-related but leaves
      // occupancy and the FIFO alone; the emergency owner tags are dropped
      // so a later release cannot end a future emergency.
      if (emergency_override) begin
         emergency_d  = 1'b0;
         em_pending_d = 1'b0;
         own_em_d     = 2'b00;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q        <= IDLE;
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         em_pending_q   <= 1'b0;
         emergency_q    <= 1'b0;
         occ_q          <= 2'b00;
         own_em_q       <= 2'b00;
         grant_id_q     <= '0;
         grant_runway_q <= 1'b0;
         rel_error_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         em_pending_q   <= em_pending_d;
         emergency_q    <= emergency_d;
         occ_q          <= occ_d;
         own_em_q       <= own_em_d;
         grant_id_q     <= grant_id_d;
         grant_runway_q <= grant_runway_d;
         rel_error_q    <= rel_error_d;
      end
      fifo_q  <= fifo_d;
      owner_q <= owner_d;
      em_id_q <= em_id_d;
   end

   assign bus.grant_valid  = (state_q == OFFER);
   assign bus.grant_id     = grant_id_q;
   assign bus.grant_runway = grant_runway_q;
   assign runway_active    = occ_q;
   assign emergency        = emergency_q;
   assign rel_error        = rel_error_q;
   assign queue_count      = count_q;
endmodule

// File: tb/tb_runway_scheduler.sv
`timescale 1ns/1ps
module tb_runway_scheduler;
   localparam int QD = 4;
   localparam int IW = 4;
   localparam int CW = $clog2(QD) + 1;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          rel_valid = 1'b0;
   logic          rel_runway = 1'b0;
   logic [IW-1:0] rel_id = '0;
   logic [1:0]    runway_override = 2'b00;
   logic          emergency_override = 1'b0;
   logic [1:0]    runway_active;
   logic          emergency;
   logic          rel_error;
   logic [CW-1:0] queue_count;

   runway_scheduler_if #(.ID_W(IW)) bus ();

   runway_scheduler #(.QUEUE_DEPTH(QD), .ID_W(IW)) dut (
      .clock              (clock),
      .reset              (reset),
      .bus                (bus.slave),
      .rel_valid          (rel_valid),
      .rel_runway         (rel_runway),
      .rel_id             (rel_id),
      .runway_override    (runway_override),
      .emergency_override (emergency_override),
      .runway_active      (runway_active),
      .emergency          (emergency),
      .rel_error          (rel_error),
      .queue_count        (queue_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct {int id; int rw;} grant_t;
   grant_t exp_q[$];
   int     m_fifo[$];
   bit     m_em_pend, m_emerg, m_offer, m_rel_err;
   int     m_em_id, m_gid, m_grw;
   bit     m_occ[2];
   bit     m_own_em[2];
   int     m_owner[2];

   always @(posedge clock) begin
      bit ready, acc, in_em, in_norm, cem, rel_hit, pend_before;
      int kind, cid, rw, rr;
      if (!reset) begin
         m_fifo.delete();
         exp_q.delete();
         m_em_pend = 0; m_emerg = 0; m_offer = 0; m_rel_err = 0;
         m_gid = 0; m_grw = 0;
         m_occ = '{0, 0};
         m_own_em = '{0, 0};
      end else begin
         ready   = (m_fifo.size() < QD) && !m_em_pend;
         acc     = bus.req_valid && ready;
         in_em   = acc && bus.req_emergency && !emergency_override;
         in_norm = acc && !bus.req_emergency;
         pend_before = m_em_pend;
         // kind: 0 none, 1 emergency slot, 2 queue head, 3 new emergency, 4 new normal
         kind = 0;
         if (m_em_pend) begin
            if (!emergency_override) kind = 1;
         end else if (!m_emerg && m_fifo.size() > 0) kind = 2;
         else if (in_em) kind = 3;
         else if (in_norm && !m_emerg) kind = 4;
         rw = -1; cid = 0; cem = 0;
         if (kind != 0 && !m_offer) begin
            cem = (kind == 1) || (kind == 3);
            cid = (kind == 1) ? m_em_id : (kind == 2) ? m_fifo[0] : int'(bus.req_id);
            for (int r = 0; r < 2; r++)
               if (rw < 0 && !m_occ[r] && (cem || !runway_override[r])) rw = r;
         end
         rr = int'(rel_runway);
         rel_hit   = rel_valid && m_occ[rr] && (m_owner[rr] == int'(rel_id));
         m_rel_err = rel_valid && !rel_hit;
         if (m_offer && bus.grant_ready) m_offer = 0;
         if (rw >= 0) begin
            m_offer = 1; m_gid = cid; m_grw = rw;
            m_occ[rw] = 1; m_owner[rw] = cid; m_own_em[rw] = cem;
            exp_q.push_back('{id: cid, rw: rw});
            if (kind == 1) m_em_pend = 0;
            if (kind == 2) void'(m_fifo.pop_front());
         end
         if (rel_hit) begin
            if (m_own_em[rr] && !pend_before) m_emerg = 0;
            m_occ[rr] = 0;
            m_own_em[rr] = 0;
         end
         if (in_em) begin
            m_emerg = 1;
            if (!(rw >= 0 && kind == 3)) begin m_em_pend = 1; m_em_id = int'(bus.req_id); end
         end
         if (in_norm && !(rw >= 0 && kind == 4)) m_fifo.push_back(int'(bus.req_id));
         if (emergency_override) begin
            m_emerg = 0; m_em_pend = 0; m_own_em = '{0, 0};
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      grant_t g;
      check("req_ready", int'(bus.req_ready), int'((m_fifo.size() < QD) && !m_em_pend));
      check("grant_valid", int'(bus.grant_valid), int'(m_offer));
      if (m_offer) begin
         check("grant_id_stable", int'(bus.grant_id), m_gid);
         check("grant_runway_stable", int'(bus.grant_runway), m_grw);
      end
      check("runway_active", int'(runway_active), int'(m_occ[1]) * 2 + int'(m_occ[0]));
      check("emergency", int'(emergency), int'(m_emerg));
      check("rel_error", int'(rel_error), int'(m_rel_err));
      check("queue_count", int'(queue_count), m_fifo.size());
      if (reset && bus.grant_valid && bus.grant_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL grant_unexpected: got id %0d rw %0d, expected no grant",
                     bus.grant_id, bus.grant_runway);
         end else begin
            g = exp_q.pop_front();
            check("sb_grant_id", int'(bus.grant_id), g.id);
            check("sb_grant_runway", int'(bus.grant_runway), g.rw);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic send_req(input int id, input bit em);
      bus.req_valid = 1'b1; bus.req_id = IW'(id); bus.req_emergency = em;
      for (int i = 0; i < 200; i++) begin
         if (bus.req_ready) begin
            tick(1);
            bus.req_valid = 1'b0; bus.req_emergency = 1'b0;
            return;
         end
         tick(1);
      end
      n_checks++; n_fail++;
      $display("FAIL send_req_timeout: id %0d not accepted, expected acceptance within 200 cycles", id);
      bus.req_valid = 1'b0; bus.req_emergency = 1'b0;
   endtask

   task automatic rel(input int rw, input int id);
      rel_valid = 1'b1; rel_runway = 1'(rw); rel_id = IW'(id);
      tick(1);
      rel_valid = 1'b0;
   endtask

   task automatic release_all();
      for (int k = 0; k < 30; k++) begin
         if (!m_occ[0] && !m_occ[1] && m_fifo.size() == 0 && !m_offer && !m_em_pend) return;
         for (int r = 0; r < 2; r++) if (m_occ[r]) rel(r, m_owner[r]);
         tick(2);
      end
   endtask

   initial begin
      bit hold, will_acc;
      int rw;
      bus.req_valid = 1'b0; bus.req_id = '0; bus.req_emergency = 1'b0; bus.grant_ready = 1'b0;

      // Reset state
      tick(3);
      check("reset_req_ready", int'(bus.req_ready), 1);
      check("reset_grant_valid", int'(bus.grant_valid), 0);
      check("reset_runway_active", int'(runway_active), 0);
      check("reset_queue_count", int'(queue_count), 0);
      check("reset_emergency", int'(emergency), 0);
      reset = 1'b1; bus.grant_ready = 1'b1;
      tick(1);

      // Single request, next-cycle grant
      send_req(3, 0);
      check("t1_grant_valid", int'(bus.grant_valid), 1);
      check("t1_grant_id", int'(bus.grant_id), 3);
      check("t1_grant_runway", int'(bus.grant_runway), 0);
      tick(1);
      check("t1_runway_active", int'(runway_active), 1);
      release_all();

      // Two runways, third request queues until a release
      send_req(1, 0); send_req(2, 0); send_req(5, 0);
      tick(4);
      check("t2_queue_count", int'(queue_count), 1);
      check("t2_runway_active", int'(runway_active), 3);
      rel(0, 1);
      tick(3);
      check("t2_after_rel_queue", int'(queue_count), 0);
      check("t2_after_rel_active", int'(runway_active), 3);
      release_all();

      // Runway overrides
      runway_override = 2'b01;
      send_req(4, 0);
      tick(2);
      check("t3_override_rw1", int'(runway_active), 2);
      release_all();
      runway_override = 2'b11;
      send_req(4, 0);
      tick(5);
      check("t3_blocked_queue", int'(queue_count), 1);
      check("t3_blocked_grant", int'(bus.grant_valid), 0);
      runway_override = 2'b00;
      tick(3);
      release_all();

      // Emergency with both runways busy and two queued
      send_req(1, 0); send_req(2, 0); send_req(6, 0); send_req(7, 0);
      send_req(9, 1);
      check("t4_emergency", int'(emergency), 1);
      check("t4_req_ready", int'(bus.req_ready), 0);
      runway_override = 2'b01;
      rel(0, 1);
      tick(3);
      check("t4_em_granted_active", int'(runway_active), 3);
      rel(0, 9);
      check("t4_emergency_clear", int'(emergency), 0);
      runway_override = 2'b00;
      release_all();

      // Invalid releases and operator cancel
      rel(1, 5);
      check("t5_rel_error_free", int'(rel_error), 1);
      check("t5_active_free", int'(runway_active), 0);
      tick(1);
      check("t5_rel_error_pulse", int'(rel_error), 0);
      send_req(1, 0); send_req(2, 0);
      tick(2);
      rel(1, 7);
      check("t5_rel_error_wrong_id", int'(rel_error), 1);
      check("t5_active_wrong_id", int'(runway_active), 3);
      send_req(9, 1);
      check("t5_em_pending", int'(emergency), 1);
      emergency_override = 1'b1;
      tick(1);
      emergency_override = 1'b0;
      check("t5_override_emergency", int'(emergency), 0);
      check("t5_override_ready", int'(bus.req_ready), 1);
      release_all();

      // Full FIFO, stalled grant, reset during OFFER
      send_req(1, 0); send_req(2, 0);
      send_req(3, 0); send_req(4, 0); send_req(5, 0); send_req(6, 0);
      tick(1);
      check("t6_full_ready", int'(bus.req_ready), 0);
      check("t6_full_count", int'(queue_count), QD);
      bus.grant_ready = 1'b0;
      rel(0, 1);
      tick(1);
      for (int i = 0; i < 10; i++) begin
         check("t6_hold_valid", int'(bus.grant_valid), 1);
         check("t6_hold_id", int'(bus.grant_id), 3);
         check("t6_hold_runway", int'(bus.grant_runway), 0);
         tick(1);
      end
      reset = 1'b0;
      tick(1);
      check("t6_rst_grant_valid", int'(bus.grant_valid), 0);
      check("t6_rst_grant_id", int'(bus.grant_id), 0);
      check("t6_rst_active", int'(runway_active), 0);
      check("t6_rst_count", int'(queue_count), 0);
      check("t6_rst_ready", int'(bus.req_ready), 1);
      check("t6_rst_emergency", int'(emergency), 0);
      reset = 1'b1; bus.grant_ready = 1'b1;
      tick(1);

      // Randomized traffic against the reference model
      hold = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!hold) begin
            bus.req_valid     = ($urandom_range(0, 99) < 40);
            bus.req_id        = IW'($urandom);
            bus.req_emergency = ($urandom_range(0, 99) < 4);
         end
         rw = int'($urandom_range(0, 1));
         rel_valid  = ($urandom_range(0, 99) < 15);
         rel_runway = 1'(rw);
         rel_id     = (m_occ[rw] && $urandom_range(0, 3) != 0) ? IW'(m_owner[rw]) : IW'($urandom);
         if (c % 50 == 0)
            runway_override = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom);
         emergency_override = ($urandom_range(0, 199) == 0);
         bus.grant_ready    = ($urandom_range(0, 2) != 0);
         will_acc = bus.req_valid && bus.req_ready;
         hold     = bus.req_valid && !will_acc;
         tick(1);
      end
      bus.req_valid = 1'b0; rel_valid = 1'b0; emergency_override = 1'b0;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
